// File: rtl/logic_unit_arbiter.sv
// Nibble-serial bitwise logic unit shared by two requesters through a
// round-robin arbiter; one operation in flight, result returned via valid/ready.
module logic_unit_arbiter #(
    parameter int WIDTH = 32,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic             rsp_err,
    output logic             busy
);
    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;
    logic             r_id;
    logic             w_grant;
    logic             w_accept;
    logic             w_last;
    logic [SLICE-1:0] w_slice;
    logic [WIDTH-1:0] w_res;

    // Illegal opcodes (11x) produce an all-zero slice.
    function automatic logic [SLICE-1:0] f_slice(input logic [2:0] op,
                                                 input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b);
        logic [SLICE-1:0] y;
        case (op)
            3'b000:  y = a & b;
            3'b001:  y = a | b;
            3'b010:  y = a ^ b;
            3'b011:  y = ~(a ^ b);
            3'b100:  y = ~a;
            3'b101:  y = ~(a & b);
            default: y = '0;
        endcase
        return y;
    endfunction

    // With both requesters valid the priority pointer decides; otherwise the valid one wins.
    assign w_grant    = (req0_valid && req1_valid) ? r_prio : req1_valid;
    assign req0_ready = (r_state == IDLE) && !w_grant && req0_valid && !rst;
    assign req1_ready = (r_state == IDLE) &&  w_grant && req1_valid && !rst;
    assign w_accept   = req0_ready || req1_ready;
    assign w_last     = (r_state == RUN) && (r_cnt == LAST);
    assign rsp_valid  = (r_state == DONE);
    assign busy       = (r_state != IDLE);

    always_comb begin
        w_slice = f_slice(r_op, r_a[r_cnt*SLICE +: SLICE], r_b[r_cnt*SLICE +: SLICE]);
        w_res   = r_acc;
        w_res[r_cnt*SLICE +: SLICE] = w_slice;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = RUN;
            RUN:     if (w_last)    w_state_nxt = DONE;
            DONE:    if (rsp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_prio <= ~w_grant;
                r_cnt  <= '0;
            end else if (r_state == RUN) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
        end
    end

    // Response registers update only on the final slice so they hold across the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_y    <= '0;
            rsp_id   <= 1'b0;
            rsp_zero <= 1'b0;
            rsp_err  <= 1'b0;
        end else if (w_last) begin
            rsp_y    <= w_res;
            rsp_id   <= r_id;
            rsp_zero <= (w_res == '0);
            rsp_err  <= r_op[2] & r_op[1];
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op  <= w_grant ? req1_op : req0_op;
            r_a   <= w_grant ? req1_a  : req0_a;
            r_b   <= w_grant ? req1_b  : req0_b;
            r_id  <= w_grant;
            r_acc <= '0;
        end else if (r_state == RUN) begin
            r_acc <= w_res;
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter with a queue scoreboard fed on accept
// and drained on each response handshake.
module tb_logic_unit_arbiter;
    localparam int WIDTH  = 32;
    localparam int NSLICE = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req0_valid = 1'b0, req1_valid = 1'b0;
    logic              req0_ready, req1_ready;
    logic [2:0]        req0_op = '0, req1_op = '0;
    logic [WIDTH-1:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic              rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_zero, rsp_err, busy;
    logic [WIDTH-1:0]  rsp_y;

    logic_unit_arbiter #(.WIDTH(WIDTH), .SLICE(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic             id;
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             err;
    } exp_t;

    exp_t sb[$];
    int   acc_cyc[$];
    int   acc_id[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc     = 0;
    int   last_acc = 0;
    logic prev_rv = 1'b0;

    always @(posedge clk) cyc++;

    function automatic logic [WIDTH-1:0] model(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return a ^ b;
            3'b011:  return ~(a ^ b);
            3'b100:  return ~a;
            3'b101:  return ~(a & b);
            default: return '0;
        endcase
    endfunction

    function automatic exp_t mk(input logic id, input logic [2:0] op,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.id   = id;
        e.y    = model(op, a, b);
        e.zero = (e.y == '0);
        e.err  = (op == 3'b110) || (op == 3'b111);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            chk("rsp_valid_in_reset", rsp_valid, 0);
        end else begin
            if (req0_ready) begin
                sb.push_back(mk(1'b0, req0_op, req0_a, req0_b));
                acc_cyc.push_back(cyc + 1);
                acc_id.push_back(0);
                last_acc = cyc + 1;
            end
            if (req1_ready) begin
                sb.push_back(mk(1'b1, req1_op, req1_a, req1_b));
                acc_cyc.push_back(cyc + 1);
                acc_id.push_back(1);
                last_acc = cyc + 1;
            end
            if (rsp_valid && !prev_rv) chk("latency", cyc - last_acc, NSLICE);
            if (rsp_valid && rsp_ready) begin
                n_total++;
                assert (sb.size() != 0) begin
                    n_pass++;
                    e = sb.pop_front();
                    chk("rsp_y", rsp_y, e.y);
                    chk("rsp_id", rsp_id, e.id);
                    chk("rsp_zero", rsp_zero, e.zero);
                    chk("rsp_err", rsp_err, e.err);
                end else $error("FAIL sb_underflow: got a response, expected none pending");
            end
        end
        prev_rv = rsp_valid;
    end

    task automatic send(input logic id, input logic [2:0] op,
                        input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic got = 1'b0;
        @(posedge clk); #1;
        if (id) begin req1_valid = 1; req1_op = op; req1_a = a; req1_b = b; end
        else    begin req0_valid = 1; req0_op = op; req0_a = a; req0_b = b; end
        for (int i = 0; i < 30 && !got; i++) begin
            @(negedge clk);
            got = id ? req1_ready : req0_ready;
        end
        chk("accept_seen", got, 1);
        @(posedge clk); #1;
        if (id) req1_valid = 0; else req0_valid = 0;
    endtask

    task automatic wait_done();
        logic got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = rsp_valid && rsp_ready;
        end
        chk("rsp_seen", got, 1);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got;
        // Reset state, ready gated by rst even with a valid request
        req0_valid = 1;
        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_rsp_y", rsp_y, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        req0_valid = 0;
        @(posedge clk); #1 rst = 0;

        // Test 1: single AND
        send(0, 3'b000, 32'hF0F0_1234, 32'hFF00_00FF);
        chk("t1_busy", busy, 1);
        chk("t1_no_ready", req0_ready, 0);
        wait_done();

        // Test 2: XOR, XNOR, NOT
        send(0, 3'b010, 32'hDEAD_BEEF, 32'hDEAD_BEEF); wait_done();
        send(1, 3'b011, 32'hDEAD_BEEF, 32'hDEAD_BEEF); wait_done();
        send(0, 3'b100, 32'h0000_FFFF, 32'h1234_5678); wait_done();

        // Test 3: round robin from reset with both requesters held valid
        do_reset();
        acc_cyc.delete(); acc_id.delete();
        req0_op = 3'b001; req0_a = 32'h0000_00F0; req0_b = 32'h0000_000F;
        req1_op = 3'b101; req1_a = 32'hFFFF_FFFF; req1_b = 32'h0000_FFFF;
        req0_valid = 1; req1_valid = 1; rsp_ready = 1;
        for (int i = 0; i < 80 && acc_id.size() < 4; i++) @(negedge clk);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        chk("rr_count", acc_id.size(), 4);
        if (acc_id.size() >= 4) begin
            chk("rr_grant0", acc_id[0], 0);
            chk("rr_grant1", acc_id[1], 1);
            chk("rr_grant2", acc_id[2], 0);
            chk("rr_grant3", acc_id[3], 1);
            for (int i = 0; i < 3; i++) chk("rr_spacing", acc_cyc[i+1] - acc_cyc[i], NSLICE + 2);
        end
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            got = !busy && (sb.size() == 0);
        end
        chk("rr_drain", got, 1);

        // Test 4: backpressure while req1 waits
        rsp_ready = 0;
        send(0, 3'b000, 32'hCAFE_F00D, 32'h0FF0_FFFF);
        @(posedge clk); #1;
        req1_valid = 1; req1_op = 3'b010; req1_a = 32'h1111_0000; req1_b = 32'h0101_0101;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rsp_valid;
        end
        chk("bp_rsp_valid_seen", got, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_rsp_valid", rsp_valid, 1);
            chk("bp_rsp_y", rsp_y, 32'hCAFE_F00D & 32'h0FF0_FFFF);
            chk("bp_rsp_id", rsp_id, 0);
            chk("bp_busy", busy, 1);
            chk("bp_ready0", req0_ready, 0);
            chk("bp_ready1", req1_ready, 0);
            @(negedge clk);
        end
        @(posedge clk); #1 rsp_ready = 1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle", busy, 0);
        chk("bp_req1_accept", req1_ready, 1);
        @(posedge clk); #1 req1_valid = 0;
        wait_done();

        // Test 5: illegal opcode
        send(1, 3'b110, 32'h1234_5678, 32'h0000_0000); wait_done();

        // Test 6: reset in the middle of req1's operation
        send(1, 3'b000, 32'hA5A5_A5A5, 32'h0F0F_0F0F);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_y", rsp_y, 0);
        chk("mid_rst_rsp_err", rsp_err, 0);
        chk("mid_rst_rsp_zero", rsp_zero, 0);
        chk("mid_rst_rsp_id", rsp_id, 0);
        @(negedge clk);
        @(posedge clk); #1 rst = 0;
        req0_valid = 1; req0_op = 3'b010; req0_a = 32'h1234_5678; req0_b = 32'hFFFF_0000;
        req1_valid = 1; req1_op = 3'b001; req1_a = 32'h0000_0001; req1_b = 32'h0000_0002;
        @(negedge clk);
        chk("post_rst_grant0", req0_ready, 1);
        chk("post_rst_grant1", req1_ready, 0);
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        wait_done();

        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shared nibble-serial bitwise logic unit with a two-requester round-robin arbiter. The unit accepts one 32-bit operation at a time (AND/OR/XOR/XNOR/NOT/NAND), computes it one SLICE-bit slice per clock, LSB slice first, and returns the result through a valid/ready response port. Instantiated where two SNN control paths (e.g. spike-mask and weight-sign logic) share one logic datapath instead of each holding a full-width gate array.

Parameters:
WIDTH, 32, operand/result width; must be an integer multiple of SLICE
SLICE, 4, bits processed per clock
NSLICE, WIDTH/SLICE (derived localparam, 8), clocks per operation

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_op  input  3  opcode, requester 0
req0_a  input  WIDTH  operand a, requester 0
req0_b  input  WIDTH  operand b, requester 0
req1_valid  input  1  requester 1 has an operation
req1_ready  output  1  requester 1 operation accepted this cycle
req1_op  input  3  opcode, requester 1
req1_a  input  WIDTH  operand a, requester 1
req1_b  input  WIDTH  operand b, requester 1
rsp_valid  output  1  response available
rsp_ready  input  1  consumer takes response
rsp_id  output  1  requester that issued the response
rsp_y  output  WIDTH  result
rsp_zero  output  1  rsp_y == 0
rsp_err  output  1  illegal opcode
busy  output  1  state != IDLE

Behaviour:
- Reset: clk and rst only; clock and reset as stated above. Asynchronous, active-high. Drives state=IDLE, prio=0, slice count=0, and all output registers to 0: rsp_valid, rsp_id, rsp_y, rsp_zero, rsp_err, busy. req0_ready and req1_ready read 0 while rst is high.
- Opcodes: 000 a&b; 001 a|b; 010 a^b; 011 ~(a^b); 100 ~a (b ignored); 101 ~(a&b); 110/111 illegal → y=0, err=1.
- FSM states: IDLE, RUN, DONE.
- IDLE, arbitration (combinational):
  - One valid: grant that requester.
  - Both valid: grant requester prio.
  - reqX_ready = (state==IDLE) & grant==X & reqX_valid & !rst.
- On the accept edge:
  - Capture op, a, b and id=X; clear the working result; count=0; state→RUN.
  - prio←~X.
  - Requester inputs may change freely after accept.
- RUN: each edge computes slice count (bits [count*SLICE +: SLICE]) into the working result, then count++. On the edge where count==NSLICE-1, load rsp_y/rsp_id/rsp_err/rsp_zero from the final values and go to DONE.
- Latency: rsp_valid is high exactly NSLICE rising edges after the accepting edge (8 for defaults).
- DONE:
  - rsp_valid=1.
  - Response outputs are held stable until the rsp_valid&rsp_ready edge, which returns to IDLE.
  - No accept is possible in DONE or RUN; both ready outputs are 0.
  - Minimum spacing between accepts is NSLICE+2 clocks.
- Response outputs hold their last values after the handshake until the next DONE load. rsp_zero is valid only with rsp_valid.
- Unused requester inputs (valid=0) are ignored entirely.
- Reset mid-operation: the in-flight operation is dropped, no response is issued, and prio returns to 0.

Test Plan:
1. Single AND: req0 op=000, a=F0F0_1234, b=FF00_00FF → req0_ready 1 cycle; rsp_valid exactly 8 edges later; rsp_y=F000_0034, rsp_id=0, rsp_zero=0, rsp_err=0.
2. XOR/XNOR: a=b=DEAD_BEEF → op 010 gives rsp_y=0000_0000, rsp_zero=1; op 011 gives FFFF_FFFF, rsp_zero=0. Also op 100, a=0000_FFFF → FFFF_0000.
3. Round robin: from reset, hold req0 and req1 valid continuously with rsp_ready=1.
   - req0 op=001, a=0000_00F0, b=0000_000F; req1 op=101, a=FFFF_FFFF, b=0000_FFFF.
   - Grants alternate 0,1,0,1; responses 0000_00FF (id0) and FFFF_0000 (id1).
   - Accepts are spaced exactly 10 clocks apart.
4. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_valid/rsp_y/rsp_id stable, busy=1, both req_ready=0 although req1_valid=1; release → IDLE next cycle, req1 accepted the following cycle.
5. Illegal opcode: req1 op=110, a=1234_5678 → rsp_y=0, rsp_err=1, rsp_zero=1, rsp_id=1.
6. Reset mid-op: assert rst after slice 3 of req1's op → outputs 0 immediately, no rsp_valid. Then both requesters valid → req0 granted first (prio=0), and its result is correct.
